divisor_restaurador: RTL and testbench
======================================

Name: divisor_restaurador

Overview:
- Sequential unsigned restoring divider; the shift-subtract inverse of the team's shift-AND partial-product multiplier.
- Produces one quotient bit per clock and computes Cociente = Dividendo / Divisor and Residuo = Dividendo % Divisor.
- Sits beside the multiplier in the arithmetic datapath.
- Start/done handshake toward the controlling FSM.

Parameters:
- TAMANO, 4, operand width in bits for dividend, divisor, quotient and remainder (legal range 2..32).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Dividendo  input  TAMANO  dividend, captured on the accepting edge.
- Divisor  input  TAMANO  divisor, captured on the accepting edge.
- busy  output  1  high while a division is in progress (CALC state).
- done  output  1  one-cycle pulse; results valid during this cycle.
- Cociente  output  TAMANO  quotient, held until the next accepted start.
- Residuo  output  TAMANO  remainder, held until the next accepted start.
- div_cero  output  1  set with done when Divisor was 0; held with results.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, Cociente=0, Residuo=0, div_cero=0, counter=0.
- Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1 on edge k, Divisor!=0:
  - Capture operands; clear the partial remainder; set counter=TAMANO.
  - Go to CALC and set busy=1. div_cero clears here.
- IDLE, start=1 on edge k, Divisor==0:
  - Go directly to DONE; done=1 after edge k.
  - Cociente = all ones, Residuo = Dividendo, div_cero=1.
- CALC step, each edge:
  - r' = {r[TAMANO-1:0], msb of the dividend shift register}, r is TAMANO+1 bits wide.
  - If r' >= {1'b0, Divisor}: r = r' - Divisor and the quotient bit is 1. Otherwise r = r' and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the quotient register. Decrement counter.
- CALC exit: on the edge where counter goes 1->0, write Cociente and Residuo (low TAMANO bits of r), go to DONE, and set busy=0.
- Latency: done is high in the cycle after edge k+TAMANO (TAMANO cycles for a nonzero divisor, 1 cycle for a zero divisor).
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start in DONE is ignored.
- start while busy or in DONE: ignored, no queuing.
- Operands may change after the accepting edge without effect.
- Divisor > Dividendo: Cociente=0, Residuo=Dividendo, full TAMANO-cycle latency (no early exit).
- Width rules: internal remainder is TAMANO+1 bits so the subtract cannot overflow. Result ports are exactly TAMANO bits.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken on the accepting edge; the CALC core is unchanged.
  - On the final CALC edge: Cociente is negated if the operand signs differ (truncation toward zero); Residuo takes the sign of Dividendo.
  - Latency is unchanged.
  - Divide by zero gives Cociente=all ones (-1), Residuo=Dividendo.
  - Most-negative / -1 gives Cociente = most-negative, Residuo=0 (wraps).
- Undefined: purely unsigned as above; no sign logic is synthesized.

Decomposition:
- Package divisor_pkg:
  - typedef enum logic [1:0] estado_t {IDLE, CALC, DONE}.
  - Function for the counter width, $clog2(TAMANO+1).
- Natural sub-module: etapa_resta.
  - Purely combinational, parameter TAMANO.
  - Inputs: partial remainder, incoming bit, divisor. Outputs: next remainder, quotient bit.
  - Instantiated once inside divisor_restaurador.

Test Plan:
- TAMANO=4, start with Dividendo=13, Divisor=4 -> done pulses 4 cycles after accept; Cociente=3, Residuo=1, div_cero=0; busy high for exactly 4 cycles.
- Dividendo=15, Divisor=1 -> Cociente=15, Residuo=0. Dividendo=5, Divisor=7 -> Cociente=0, Residuo=5, latency still 4.
- Divisor=0, Dividendo=9 -> done 1 cycle after accept; Cociente=4'hF, Residuo=9, div_cero=1; next valid division clears div_cero.
- start asserted every cycle while busy with changing operands -> only the first request is processed; exactly one done per accepted start; results held until the next start.
- Assert rst for 1 cycle at the 2nd CALC cycle -> no done pulse; all outputs 0; a new 13/4 then completes correctly.
- With DIV_SIGNED_EN: -7/2 -> Cociente=4'hD (-3), Residuo=4'hF (-1); 7/-2 -> Cociente=4'hD, Residuo=1.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared types and helpers for the restoring divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } estado_t;

    function automatic int ancho_contador(input int tamano);
        return $clog2(tamano + 1);
    endfunction

endpackage

// File: rtl/etapa_resta.sv
// One restoring shift-subtract step: brings in one dividend bit, yields one quotient bit.
module etapa_resta
    import divisor_pkg::*;
#(
    parameter int TAMANO = 4
) (
    input  logic [TAMANO-1:0] resto,
    input  logic              bit_in,
    input  logic [TAMANO-1:0] divisor,
    output logic [TAMANO-1:0] resto_sig,
    output logic              bit_q
);

    // The stored remainder is always below the divisor, so its extra top bit is
    // always zero and only the low TAMANO bits need to be carried between steps.
    logic [TAMANO:0] desplazado;
    logic [TAMANO:0] restado;

    assign desplazado = {resto, bit_in};
    assign restado    = desplazado - {1'b0, divisor};

    always_comb begin
        bit_q     = 1'b0;
        resto_sig = desplazado[TAMANO-1:0];
        if (desplazado >= {1'b0, divisor}) begin
            bit_q     = 1'b1;
            resto_sig = restado[TAMANO-1:0];
        end
    end

endmodule

// File: rtl/divisor_restaurador.sv
// Sequential restoring divider, one quotient bit per clock with a start/done handshake.
// Optional macro DIV_SIGNED_EN: two's-complement operands, truncation toward zero.
//
// state | meaning
// IDLE  | waiting for start; results from the last division are held
// CALC  | one shift-subtract step per cycle, counter runs TAMANO down to 0
// DONE  | done pulse for one cycle, then back to IDLE
module divisor_restaurador
    import divisor_pkg::*;
#(
    parameter int TAMANO = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TAMANO-1:0] Dividendo,
    input  logic [TAMANO-1:0] Divisor,
    output logic              busy,
    output logic              done,
    output logic [TAMANO-1:0] Cociente,
    output logic [TAMANO-1:0] Residuo,
    output logic              div_cero
);

    localparam int CW = ancho_contador(TAMANO);
    localparam logic [CW-1:0] CNT_INI = CW'(TAMANO);

    estado_t           estado;
    logic [CW-1:0]     cnt;
    logic [TAMANO-1:0] resto;
    logic [TAMANO-1:0] dvd_sr;
    logic [TAMANO-1:0] dvs;
    logic [TAMANO-1:0] q;

    logic [TAMANO-1:0] resto_sig;
    logic              bit_q;
    logic [TAMANO-1:0] q_fin;
    logic [TAMANO-1:0] dvd_mag;
    logic [TAMANO-1:0] dvs_mag;
    logic [TAMANO-1:0] cociente_fin;
    logic [TAMANO-1:0] residuo_fin;

    etapa_resta #(.TAMANO(TAMANO)) u_etapa (
        .resto     (resto),
        .bit_in    (dvd_sr[TAMANO-1]),
        .divisor   (dvs),
        .resto_sig (resto_sig),
        .bit_q     (bit_q)
    );

    assign q_fin = {q[TAMANO-2:0], bit_q};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Negating the most-negative value leaves its bit pattern unchanged, which
    // is already the correct unsigned magnitude for the core.
    assign dvd_mag      = Dividendo[TAMANO-1] ? -Dividendo : Dividendo;
    assign dvs_mag      = Divisor[TAMANO-1]   ? -Divisor   : Divisor;
    assign cociente_fin = neg_q ? -q_fin : q_fin;
    assign residuo_fin  = neg_r ? -resto_sig : resto_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (estado == IDLE && start) begin
            neg_q <= Dividendo[TAMANO-1] ^ Divisor[TAMANO-1];
            neg_r <= Dividendo[TAMANO-1];
        end
    end
`else
    assign dvd_mag      = Dividendo;
    assign dvs_mag      = Divisor;
    assign cociente_fin = q_fin;
    assign residuo_fin  = resto_sig;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Cociente <= '0;
            Residuo  <= '0;
            div_cero <= 1'b0;
            cnt      <= '0;
            resto    <= '0;
            dvd_sr   <= '0;
            dvs      <= '0;
            q        <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (Divisor == '0) begin
                            Cociente <= '1;
                            Residuo  <= Dividendo;
                            div_cero <= 1'b1;
                            done     <= 1'b1;
                            estado   <= DONE;
                        end else begin
                            dvd_sr   <= dvd_mag;
                            dvs      <= dvs_mag;
                            resto    <= '0;
                            q        <= '0;
                            cnt      <= CNT_INI;
                            div_cero <= 1'b0;
                            busy     <= 1'b1;
                            estado   <= CALC;
                        end
                    end
                end
                CALC: begin
                    resto  <= resto_sig;
                    dvd_sr <= {dvd_sr[TAMANO-2:0], 1'b0};
                    q      <= q_fin;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        Cociente <= cociente_fin;
                        Residuo  <= residuo_fin;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        estado   <= DONE;
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    estado <= IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_restaurador.sv
// Directed bench for divisor_restaurador (TAMANO=4); follows DIV_SIGNED_EN if defined.
module tb_divisor_restaurador;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] Dividendo;
    logic [3:0] Divisor;
    logic       busy;
    logic       done;
    logic [3:0] Cociente;
    logic [3:0] Residuo;
    logic       div_cero;

    int n_cmp = 0;
    int n_err = 0;

    divisor_restaurador #(.TAMANO(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Dividendo (Dividendo),
        .Divisor   (Divisor),
        .busy      (busy),
        .done      (done),
        .Cociente  (Cociente),
        .Residuo   (Residuo),
        .div_cero  (div_cero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one division, then follow it to the done pulse and one cycle beyond.
    task automatic run_div(input string tag, input logic [3:0] dvd, input logic [3:0] dvs,
                           input logic [3:0] eq, input logic [3:0] er, input logic ez,
                           input int elat);
        int n;
        int nbusy;
        n = 0;
        nbusy = 0;
        start = 1'b1;
        Dividendo = dvd;
        Divisor = dvs;
        tick();
        start = 1'b0;
        Dividendo = 4'h0;
        Divisor = 4'h0;
        chk({tag, "_dz_accept"}, 32'(div_cero), 32'(ez));
        while (!done && n < 40) begin
            nbusy += int'(busy);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(elat));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(elat));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_cociente"}, 32'(Cociente), 32'(eq));
        chk({tag, "_residuo"}, 32'(Residuo), 32'(er));
        chk({tag, "_div_cero"}, 32'(div_cero), 32'(ez));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_cociente_held"}, 32'(Cociente), 32'(eq));
    endtask

    initial begin
        int n;
        int ndone;

        rst = 1'b1;
        start = 1'b0;
        Dividendo = 4'h0;
        Divisor = 4'h0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cociente", 32'(Cociente), 32'd0);
        chk("rst_residuo", 32'(Residuo), 32'd0);
        chk("rst_div_cero", 32'(div_cero), 32'd0);
        rst = 1'b0;
        tick();

        // Values valid in both unsigned and signed interpretation.
        run_div("d7_2", 4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 4);
        run_div("d5_7", 4'd5, 4'd7, 4'd0, 4'd5, 1'b0, 4);
        run_div("d9_0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 0);
`ifdef DIV_SIGNED_EN
        run_div("dm7_2", 4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 4);
        run_div("d7_m2", 4'd7, 4'hE, 4'hD, 4'd1, 1'b0, 4);
        run_div("dm8_m1", 4'h8, 4'hF, 4'h8, 4'd0, 1'b0, 4);
        run_div("dm3_4", 4'd13, 4'd4, 4'd0, 4'hD, 1'b0, 4);
`else
        run_div("d13_4", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4);
        run_div("d15_1", 4'd15, 4'd1, 4'hF, 4'd0, 1'b0, 4);
        run_div("d15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);
`endif

        // start held high the whole time with operands changing under it.
        start = 1'b1;
        Dividendo = 4'd6;
        Divisor = 4'd4;
        tick();
        n = 0;
        while (!done && n < 40) begin
            Dividendo = 4'($urandom_range(0, 15));
            Divisor = 4'($urandom_range(1, 15));
            tick();
            n++;
        end
        chk("hold_latency", 32'(n), 32'd4);
        chk("hold_cociente", 32'(Cociente), 32'd1);
        chk("hold_residuo", 32'(Residuo), 32'd2);
        tick();
        chk("hold_start_in_done", 32'(busy | done), 32'd0);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ndone += int'(done);
        end
        chk("hold_extra_done", 32'(ndone), 32'd0);
        chk("hold_results_kept", 32'({Cociente, Residuo}), 32'h12);

        // Reset during the second CALC cycle aborts the division.
        start = 1'b1;
        Dividendo = 4'd13;
        Divisor = 4'd4;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_results", 32'({Cociente, Residuo}), 32'h0);
        chk("abort_div_cero", 32'(div_cero), 32'd0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            ndone += int'(done);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
`ifdef DIV_SIGNED_EN
        run_div("after_abort", 4'd13, 4'd4, 4'd0, 4'hD, 1'b0, 4);
`else
        run_div("after_abort", 4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
